btb_update_ctrl: RTL and testbench

//  Writer side of the branch target buffer; the BTB's fetch side only reads it.

---
 rtl/btb_pkg.sv | 16 +
 rtl/btb_upd_queue.sv | 82 ++++++++
 rtl/btb_update_ctrl.sv | 117 +++++++++++
 tb/tb_btb_update_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update controller.
package btb_pkg;
    localparam int BTB_WIDTH   = 31;
    localparam int BTB_B_WIDTH = 7;
    localparam int BTB_DEPTH   = 8;
    localparam int BTB_TAG_W   = 3;
    localparam int PC_STEP     = 4;

    typedef struct packed {
        logic                 valid;
        logic                 resolved;
        logic                 predTaken;
        logic [BTB_WIDTH:0]   pc;
        logic [BTB_WIDTH:0]   predTgt;
    } btb_entry_t;
endpackage

// File: rtl/btb_upd_queue.sv
// In-order circular queue of in-flight branches: head/tail/count bookkeeping,
// per-entry resolved marking, in-order commit and squash of entries younger than a tag.
module btb_upd_queue
    import btb_pkg::*;
#(
    parameter int DEPTH = BTB_DEPTH,
    parameter int TAG_W = BTB_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_alloc_valid,
    input  btb_entry_t       i_alloc_entry,
    input  logic             i_resolve_en,
    input  logic [TAG_W-1:0] i_resolve_tag,
    input  logic             i_squash_en,
    input  logic             i_commit_valid,
    output btb_entry_t       o_rd_entry,
    output logic [TAG_W-1:0] o_tail,
    output logic             o_full
);
    btb_entry_t       r_entries [DEPTH];
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;

    logic             w_alloc;
    logic             w_commit;
    logic [TAG_W-1:0] w_tag_off;
    logic [TAG_W:0]   w_keep;
    logic [DEPTH-1:0] w_younger;

    assign o_full     = (r_count == (TAG_W+1)'(DEPTH));
    assign o_tail     = r_tail;
    assign o_rd_entry = r_entries[i_resolve_tag];

    // A squash redirects fetch, so whatever was fetched alongside it is wrong-path.
    assign w_alloc   = i_alloc_valid && !o_full && !i_squash_en;
    assign w_commit  = i_commit_valid && r_entries[r_head].valid && r_entries[r_head].resolved;
    assign w_tag_off = i_resolve_tag - r_head;
    // Entries head..tag survive; the +1 naturally yields DEPTH when tag is the last slot.
    assign w_keep    = {1'b0, w_tag_off} + (TAG_W+1)'(1);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [TAG_W-1:0] w_off;
            assign w_off         = TAG_W'(gi) - r_head;
            assign w_younger[gi] = r_entries[gi].valid && (w_off > w_tag_off);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc && r_tail == TAG_W'(i)) begin
                    r_entries[i] <= i_alloc_entry;
                end else if ((w_commit && r_head == TAG_W'(i)) ||
                             (i_squash_en && w_younger[i])) begin
                    r_entries[i].valid    <= 1'b0;
                    r_entries[i].resolved <= 1'b0;
                end else if (i_resolve_en && i_resolve_tag == TAG_W'(i)) begin
                    r_entries[i].resolved <= 1'b1;
                end
            end

            r_head <= r_head + TAG_W'(w_commit);
            if (i_squash_en) begin
                r_tail  <= i_resolve_tag + TAG_W'(1);
                r_count <= w_keep - (TAG_W+1)'(w_commit);
            end else begin
                r_tail  <= r_tail + TAG_W'(w_alloc);
                r_count <= r_count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_commit);
            end
        end
    end
endmodule

// File: rtl/btb_update_ctrl.sv
// BTB writer: compares branch resolution against fetch-time prediction, issues BTB writes,
// mispredict redirects and flush tags. Define BTB_UPD_STATS_EN for resolve/mispredict counters.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int WIDTH   = BTB_WIDTH,
    parameter int B_WIDTH = BTB_B_WIDTH,
    parameter int DEPTH   = BTB_DEPTH,
    parameter int TAG_W   = BTB_TAG_W
) (
    input  logic               clk,
    input  logic               reset,
`ifdef BTB_UPD_STATS_EN
    output logic [15:0]        statResolved,
    output logic [15:0]        statMispred,
`endif
    input  logic               allocValid,
    input  logic [WIDTH:0]     allocPC,
    input  logic               allocPredTaken,
    input  logic [WIDTH:0]     allocPredTgt,
    output logic [TAG_W-1:0]   allocTag,
    output logic               full,
    input  logic               resolveValid,
    input  logic [TAG_W-1:0]   resolveTag,
    input  logic               resolveTaken,
    input  logic [WIDTH:0]     resolveTarget,
    input  logic               commitValid,
    output logic               writeBTB,
    output logic [B_WIDTH:0]   oldPC,
    output logic [WIDTH:0]     resolvedTarget,
    output logic               takenBranch,
    output logic               mispredict,
    output logic [WIDTH:0]     redirectPC,
    output logic [TAG_W-1:0]   flushTag
);
    btb_entry_t       w_alloc_entry;
    btb_entry_t       w_rd;
    logic             w_accept;
    logic             w_tgt_diff;
    logic             w_mis;
    logic             w_write;
    logic [WIDTH:0]   w_redirect;

    always_comb begin
        w_alloc_entry           = '0;
        w_alloc_entry.valid     = 1'b1;
        w_alloc_entry.predTaken = allocPredTaken;
        w_alloc_entry.pc        = allocPC;
        w_alloc_entry.predTgt   = allocPredTgt;
    end

    // Only the first resolve of a live entry counts; stale tags and repeats fall through.
    assign w_accept   = resolveValid && w_rd.valid && !w_rd.resolved;
    assign w_tgt_diff = (w_rd.predTgt != resolveTarget);
    assign w_mis      = (w_rd.predTaken != resolveTaken) |
                        (w_rd.predTaken & resolveTaken & w_tgt_diff);
    assign w_write    = resolveTaken ? (!w_rd.predTaken | w_tgt_diff) : w_rd.predTaken;
    assign w_redirect = resolveTaken ? resolveTarget : (w_rd.pc + (WIDTH+1)'(PC_STEP));

    btb_upd_queue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_queue (
        .clk            (clk),
        .reset          (reset),
        .i_alloc_valid  (allocValid),
        .i_alloc_entry  (w_alloc_entry),
        .i_resolve_en   (w_accept),
        .i_resolve_tag  (resolveTag),
        .i_squash_en    (w_accept && w_mis),
        .i_commit_valid (commitValid),
        .o_rd_entry     (w_rd),
        .o_tail         (allocTag),
        .o_full         (full)
    );

    // Registered on posedge so the BTB can sample a stable value on its negedge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            writeBTB       <= 1'b0;
            oldPC          <= '0;
            resolvedTarget <= '0;
            takenBranch    <= 1'b0;
            mispredict     <= 1'b0;
            redirectPC     <= '0;
            flushTag       <= '0;
        end else begin
            writeBTB   <= w_accept && w_write;
            mispredict <= w_accept && w_mis;
            if (w_accept) begin
                oldPC          <= w_rd.pc[B_WIDTH:0];
                resolvedTarget <= resolveTarget;
                takenBranch    <= resolveTaken;
                redirectPC     <= w_redirect;
                if (w_mis) begin
                    flushTag <= resolveTag;
                end
            end
        end
    end

`ifdef BTB_UPD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            statResolved <= '0;
            statMispred  <= '0;
        end else begin
            if (w_accept && statResolved != 16'hFFFF) begin
                statResolved <= statResolved + 16'd1;
            end
            if (w_accept && w_mis && statMispred != 16'hFFFF) begin
                statMispred <= statMispred + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed plus randomized bench for btb_update_ctrl against an in-order queue model.
module tb_btb_update_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        allocValid;
    logic [31:0] allocPC;
    logic        allocPredTaken;
    logic [31:0] allocPredTgt;
    logic [2:0]  allocTag;
    logic        full;
    logic        resolveValid;
    logic [2:0]  resolveTag;
    logic        resolveTaken;
    logic [31:0] resolveTarget;
    logic        commitValid;
    logic        writeBTB;
    logic [7:0]  oldPC;
    logic [31:0] resolvedTarget;
    logic        takenBranch;
    logic        mispredict;
    logic [31:0] redirectPC;
    logic [2:0]  flushTag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  tag;
        logic [31:0] pc;
        bit          pt;
        logic [31:0] tgt;
        bit          res;
    } ment_t;

    ment_t      mq[$];
    logic [2:0] m_tail;

    btb_update_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .allocValid     (allocValid),
        .allocPC        (allocPC),
        .allocPredTaken (allocPredTaken),
        .allocPredTgt   (allocPredTgt),
        .allocTag       (allocTag),
        .full           (full),
        .resolveValid   (resolveValid),
        .resolveTag     (resolveTag),
        .resolveTaken   (resolveTaken),
        .resolveTarget  (resolveTarget),
        .commitValid    (commitValid),
        .writeBTB       (writeBTB),
        .oldPC          (oldPC),
        .resolvedTarget (resolvedTarget),
        .takenBranch    (takenBranch),
        .mispredict     (mispredict),
        .redirectPC     (redirectPC),
        .flushTag       (flushTag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; allocValid = 1'b0; allocPC = '0; allocPredTaken = 1'b0; allocPredTgt = '0;
        resolveValid = 1'b0; resolveTag = '0; resolveTaken = 1'b0; resolveTarget = '0; commitValid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_writeBTB", 32'(writeBTB), 32'd0);
        chk("rst_oldPC", 32'(oldPC), 32'd0);
        chk("rst_resolvedTarget", resolvedTarget, 32'd0);
        chk("rst_takenBranch", 32'(takenBranch), 32'd0);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_redirectPC", redirectPC, 32'd0);
        chk("rst_flushTag", 32'(flushTag), 32'd0);
        chk("rst_allocTag", 32'(allocTag), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        mq.delete();
        m_tail = 3'd0;
        $display("txn reset");
        @(negedge clk);
    endtask

    // One clock of stimulus; the model decides what the design must do this cycle.
    task automatic step(input bit av, input logic [31:0] apc, input bit apt, input logic [31:0] atgt,
                        input bit rv, input logic [2:0] rtag, input bit rtk, input logic [31:0] rtgt,
                        input bit cv);
        int          ri;
        bit          acc, stale, cok, do_alloc;
        logic [31:0] redir;
        allocValid = av; allocPC = apc; allocPredTaken = apt; allocPredTgt = atgt;
        resolveValid = rv; resolveTag = rtag; resolveTaken = rtk; resolveTarget = rtgt;
        commitValid = cv;
        #1;
        chk("allocTag", 32'(allocTag), 32'(m_tail));
        chk("full", 32'(full), 32'(mq.size() == 8));

        ri = -1;
        foreach (mq[k]) if (mq[k].tag == rtag && !mq[k].res) ri = k;
        acc   = rv && (ri >= 0);
        stale = 1'b0;
        redir = '0;
        if (acc) begin
            // The BTB should hold {valid, target} iff taken; any difference is both a
            // stale BTB entry (needs a write) and a wrong fetch path (mispredict).
            stale = (mq[ri].pt != rtk) || (rtk && mq[ri].tgt != rtgt);
            redir = rtk ? rtgt : mq[ri].pc + 32'd4;
        end
        cok      = cv && mq.size() > 0 && mq[0].res;
        do_alloc = av && mq.size() < 8 && !stale;

        @(posedge clk); #1;
        chk("writeBTB", 32'(writeBTB), 32'(stale));
        chk("mispredict", 32'(mispredict), 32'(stale));
        if (acc) begin
            chk("oldPC", 32'(oldPC), 32'(mq[ri].pc[7:0]));
            chk("resolvedTarget", resolvedTarget, rtgt);
            chk("takenBranch", 32'(takenBranch), 32'(rtk));
            chk("redirectPC", redirectPC, redir);
            if (stale) chk("flushTag", 32'(flushTag), 32'(rtag));
        end

        if (acc) begin
            mq[ri].res = 1'b1;
            if (stale) begin
                while (mq.size() > ri + 1) void'(mq.pop_back());
                m_tail = rtag + 3'd1;
            end
        end
        if (cok) void'(mq.pop_front());
        if (do_alloc) begin
            mq.push_back('{m_tail, apc, apt, atgt, 1'b0});
            m_tail = m_tail + 3'd1;
        end
        $display("txn alloc=%0b pc=%0h resolve=%0b tag=%0d taken=%0b tgt=%0h commit=%0b accepted=%0b mis=%0b inflight=%0d",
                 av, apc, rv, rtag, rtk, rtgt, cv, acc, stale, mq.size());
        @(negedge clk);
    endtask

    task automatic alloc(input logic [31:0] pc, input bit pt, input logic [31:0] tgt);
        step(1'b1, pc, pt, tgt, 1'b0, 3'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic resolve(input logic [2:0] tag, input bit tk, input logic [31:0] tgt);
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, tag, tk, tgt, 1'b0);
    endtask

    task automatic commit();
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        logic [31:0] tgts [2];
        tgts[0] = 32'h100;
        tgts[1] = 32'h200;
        reset = 1'b1;
        allocValid = 1'b0; allocPC = '0; allocPredTaken = 1'b0; allocPredTgt = '0;
        resolveValid = 1'b0; resolveTag = '0; resolveTaken = 1'b0; resolveTarget = '0; commitValid = 1'b0;
        @(negedge clk);
        do_reset();

        // New taken branch gets installed and redirects fetch
        alloc(32'h40, 1'b0, 32'h0);
        resolve(3'd0, 1'b1, 32'h100);
        chk("t1_writeBTB", 32'(writeBTB), 32'd1);
        chk("t1_oldPC", 32'(oldPC), 32'h40);
        chk("t1_mispredict", 32'(mispredict), 32'd1);
        chk("t1_redirectPC", redirectPC, 32'h100);
        commit();

        // Correct taken prediction: no write; same branch going not-taken: invalidate
        alloc(32'h44, 1'b1, 32'h80);
        resolve(3'd1, 1'b1, 32'h80);
        chk("t2_nowrite", 32'(writeBTB), 32'd0);
        do_reset();
        alloc(32'h44, 1'b1, 32'h80);
        resolve(3'd0, 1'b0, 32'h0);
        chk("t2_takenBranch", 32'(takenBranch), 32'd0);
        chk("t2_redirectPC", redirectPC, 32'h48);

        // Fill, overflow attempt, commit frees one slot
        do_reset();
        for (int i = 0; i < 8; i++) alloc(32'h1000 + 32'(i) * 4, 1'b1, 32'h200);
        chk("t3_full", 32'(full), 32'd1);
        alloc(32'h2000, 1'b0, 32'h0);
        resolve(3'd0, 1'b1, 32'h200);
        commit();
        chk("t3_notfull", 32'(full), 32'd0);
        alloc(32'h2004, 1'b0, 32'h0);
        chk("t3_refull", 32'(full), 32'd1);

        // Squash younger than tag 2, then stale and duplicate resolves
        do_reset();
        for (int i = 0; i < 6; i++) alloc(32'h300 + 32'(i) * 4, 1'b0, 32'h0);
        resolve(3'd2, 1'b1, 32'h500);
        chk("t4_tail", 32'(allocTag), 32'd3);
        resolve(3'd4, 1'b0, 32'h0);
        chk("t4_stale_mis", 32'(mispredict), 32'd0);
        resolve(3'd1, 1'b1, 32'h600);
        resolve(3'd1, 1'b0, 32'h0);
        commit();
        for (int i = 0; i < 6; i++) alloc(32'h700 + 32'(i) * 4, 1'b0, 32'h0);

        // Reset with branches in flight and a pending redirect
        do_reset();
        for (int i = 0; i < 5; i++) alloc(32'h900 + 32'(i) * 4, 1'b0, 32'h0);
        resolve(3'd3, 1'b1, 32'h100);
        do_reset();

        for (int n = 0; n < 400; n++) begin
            bit          av, apt, rv, rtk, cv;
            logic [31:0] apc, atgt, rtgt;
            logic [2:0]  rtag;
            av   = ($urandom_range(0, 99) < 60);
            apc  = 32'($urandom_range(0, 1023)) << 2;
            apt  = 1'($urandom_range(0, 1));
            atgt = tgts[$urandom_range(0, 1)];
            rv   = ($urandom_range(0, 99) < 45);
            if (mq.size() > 0 && $urandom_range(0, 99) < 80)
                rtag = mq[$urandom_range(0, mq.size() - 1)].tag;
            else
                rtag = 3'($urandom_range(0, 7));
            rtk  = ($urandom_range(0, 99) < 40) ? apt : 1'($urandom_range(0, 1));
            rtgt = tgts[$urandom_range(0, 1)];
            cv   = ($urandom_range(0, 99) < 50);
            step(av, apc, apt, atgt, rv, rtag, rtk, rtgt, cv);
            if (n % 150 == 149) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
